// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling and vote constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int VOTE_LO    = 7;
  localparam int VOTE_MID   = 8;
  localparam int VOTE_HI    = 9;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } rx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } rx_state_t;
`endif

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte handoff between the UART receive deframer (master) and its consumer (slave).
interface uart_rx_deframer_if;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_parity_err;

  modport master (
    input  rx_ack,
    output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err
  );

  modport slave (
    output rx_ack,
    input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: counts 0..DIV-1 and flags the last count.
// Shared by the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampling, 7/8/9 majority vote, stop check, valid/ack handoff.
// Even parity is added when UART_RX_PARITY_EN is defined.
//
// state     | meaning
// IDLE      | line idle, looking for a low sample on tick
// START     | confirming the start bit at mid-bit
// DATA      | shifting in data bits, LSB first
// PARITY    | capturing the parity bit (UART_RX_PARITY_EN only)
// STOP      | checking the stop bit at sample 9
// WAIT_IDLE | stop bit was low; hold until the line returns high
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               UART_RX,
  uart_rx_deframer_if.master rx
);
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);

  logic                 rx_m, rx_s, tick;
  rx_state_t            state;
  logic [3:0]           sample_cnt;
  logic [2:0]           samples;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, overrun_q, frame_err_q;
  logic                 vote_full, vote_stop, at_last, stop_check, parity_ok, deliver;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, parity_err_q;
`endif

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .tick   (tick)
  );

  // The stop decision is taken on the count-9 tick itself, so its third vote is the live sample.
  always_comb begin
    vote_full  = majority3(samples[0], samples[1], samples[2]);
    vote_stop  = majority3(samples[0], samples[1], rx_s);
    at_last    = tick && (sample_cnt == LAST_SAMPLE);
    stop_check = tick && (state == STOP) && (sample_cnt == 4'(VOTE_HI));
`ifdef UART_RX_PARITY_EN
    parity_ok  = (par_bit == ^shreg);
`else
    parity_ok  = 1'b1;
`endif
    deliver    = stop_check && vote_stop && parity_ok;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      sample_cnt  <= '0;
      samples     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_m        <= UART_RX;
      rx_s        <= rx_m;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      if (tick) begin
        if (sample_cnt == 4'(VOTE_LO))  samples[0] <= rx_s;
        if (sample_cnt == 4'(VOTE_MID)) samples[1] <= rx_s;
        if (sample_cnt == 4'(VOTE_HI))  samples[2] <= rx_s;
      end

      case (state)
        IDLE: begin
          if (tick && !rx_s) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (at_last) begin
              if (!vote_full) begin
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (at_last) begin
              shreg   <= {vote_full, shreg[DATA_BITS-1:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (at_last) begin
              par_bit <= vote_full;
              state   <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
            if (stop_check) begin
              if (!vote_stop) begin
                frame_err_q <= 1'b1;
                state       <= WAIT_IDLE;
              end else begin
`ifdef UART_RX_PARITY_EN
                if (!parity_ok) parity_err_q <= 1'b1;
`endif
                state <= IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // An ack landing on a delivery cycle frees the holding slot for the new byte.
      if (deliver) begin
        if (!valid_q || rx.rx_ack) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx.rx_ack && valid_q) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_overrun   = overrun_q;
  assign rx.rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx.rx_parity_err = parity_err_q;
`else
  assign rx.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed frames plus random frames against a frame-level model.
module tb_uart_rx_deframer;
  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 25_000;
  localparam int DIV     = CLK_HZ / (BAUD * 16);
  localparam int BIT_CYC = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic line;

  uart_rx_deframer_if bus();

  uart_rx_deframer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .sysclk  (clk),
    .reset   (reset),
    .UART_RX (line),
    .rx      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fe_seen  = 0;
  int pe_seen  = 0;

  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_overrun;
  int         exp_fe;
  int         exp_pe;

  // Every high cycle counts, so a pulse wider than one cycle shows up as an extra event.
  always @(negedge clk) begin
    if (bus.rx_frame_err)  fe_seen++;
    if (bus.rx_parity_err) pe_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"},    32'(bus.rx_data),    32'(exp_data));
    check({tag, "_valid"},   32'(bus.rx_valid),   32'(exp_valid));
    check({tag, "_overrun"}, 32'(bus.rx_overrun), 32'(exp_overrun));
    check({tag, "_frm_err"}, 32'(fe_seen),        32'(exp_fe));
    check({tag, "_par_err"}, 32'(pe_seen),        32'(exp_pe));
  endtask

  task automatic drive_bit(input logic b);
    line = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic idle(input int nbits);
    line = 1'b1;
    repeat (nbits * BIT_CYC) @(negedge clk);
  endtask

  task automatic ack_pulse(input string tag);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    if (exp_valid) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
    check({tag, "_ack_valid"},   32'(bus.rx_valid),   32'(exp_valid));
    check({tag, "_ack_overrun"}, 32'(bus.rx_overrun), 32'(exp_overrun));
  endtask

  // One whole frame, checked at the end of its stop bit. held keeps rx_ack high throughout.
  task automatic run_frame(input logic [7:0] b, input bit stop, input bit par_good,
                           input bit held, input string tag);
    logic par;
    bit   good;
    par = par_good ? ^b : ~^b;
    if (held) bus.rx_ack = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);

    good = stop && (!PAR_EN || par_good);
    if (held) begin
      exp_valid   = 1'b0;
      exp_overrun = 1'b0;
    end
    if (!stop) begin
      exp_fe++;
    end else if (!good) begin
      exp_pe++;
    end else if (!exp_valid) begin
      exp_data  = b;
      exp_valid = 1'b1;
    end else begin
      exp_overrun = 1'b1;
    end
    if (held) exp_valid = 1'b0;

    check_outputs(tag);
    if (held) bus.rx_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    bit         rstop, rpar, rheld;
    int         gap;

    reset       = 1'b1;
    line        = 1'b1;
    bus.rx_ack  = 1'b0;
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    exp_fe      = 0;
    exp_pe      = 0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;
    idle(1);

    run_frame(8'h55, 1'b1, 1'b1, 1'b0, "f55");

    ack_pulse("pre_glitch");
    line = 1'b0;
    repeat (18) @(negedge clk);
    idle(3);
    check_outputs("glitch");

    run_frame(8'hA3, 1'b0, 1'b1, 1'b0, "fA3_badstop");
    idle(1);
    run_frame(8'h0F, 1'b1, 1'b1, 1'b0, "f0F");

    ack_pulse("pre_b2b");
    run_frame(8'h12, 1'b1, 1'b1, 1'b0, "b2b_12");
    run_frame(8'h34, 1'b1, 1'b1, 1'b0, "b2b_34");
    ack_pulse("b2b");

    idle(1);
    run_frame(8'h99, 1'b1, 1'b1, 1'b0, "f99");
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    reset = 1'b1;
    line  = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    exp_data    = 8'h00;
    exp_valid   = 1'b0;
    exp_overrun = 1'b0;
    check_outputs("mid_reset");
    check("mid_reset_frm_pulse", 32'(bus.rx_frame_err),  32'd0);
    check("mid_reset_par_pulse", 32'(bus.rx_parity_err), 32'd0);
    idle(2);
    run_frame(8'hC6, 1'b1, 1'b1, 1'b0, "fC6");

    if (PAR_EN) begin
      ack_pulse("pre_parity");
      run_frame(8'h07, 1'b1, 1'b0, 1'b0, "f07_badpar");
      idle(1);
      run_frame(8'h07, 1'b1, 1'b1, 1'b0, "f07_goodpar");
    end

    idle(1);
    for (int n = 0; n < 24; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rpar  = ($urandom_range(0, 7) != 0);
      rheld = ($urandom_range(0, 5) == 0);
      run_frame(rb, rstop, rpar, rheld, "rand");
      if (!rstop) begin
        idle(1 + int'($urandom_range(0, 1)));
      end else begin
        gap = int'($urandom_range(0, 2));
        if (gap > 0) begin
          line = 1'b1;
          if ($urandom_range(0, 1) == 1) ack_pulse("rand");
          idle(gap);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
